alu_operand_sequencer: RTL and testbench

Sequential front end for the N-bit ALU on the DE10-Lite board. Instead of driving the ALU straight from switches, the operator enters operand A, then operand B and the ALU control, one push-button press at a time. The block synchronises and debounces the button and presents registered operands and a commit strobe to the ALU. It then captures the ALU result and carry into registers that feed the HEX decoders and LEDs.

---
 rtl/alu_operand_sequencer_if.sv | 27 ++
 rtl/alu_operand_sequencer.sv | 115 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: key/switch inputs, ALU result feedback and registered
// operand/result outputs of the operand sequencer, grouped as one bus.
interface alu_operand_sequencer_if #(
  parameter int N = 4
);
  logic         i_key;
  logic [N-1:0] i_sw;
  logic [1:0]   i_ctrl_sw;
  logic [N-1:0] i_result;
  logic         i_carry_out;
  logic [N-1:0] o_a;
  logic [N-1:0] o_b;
  logic [1:0]   o_alu_ctrl;
  logic         o_valid;
  logic [N-1:0] o_result;
  logic         o_carry;
  logic [1:0]   o_state;
  logic         o_done;
  modport slave (
    input  i_key, i_sw, i_ctrl_sw, i_result, i_carry_out,
    output o_a, o_b, o_alu_ctrl, o_valid, o_result, o_carry, o_state, o_done
  );
  modport master (
    output i_key, i_sw, i_ctrl_sw, i_result, i_carry_out,
    input  o_a, o_b, o_alu_ctrl, o_valid, o_result, o_carry, o_state, o_done
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: push-button stepped operand entry and result capture for the ALU.
// Define ALU_SEQ_DEBOUNCE_EN to insert the DEBOUNCE_CYCLES key debouncer.
module alu_operand_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  alu_operand_sequencer_if.slave bus
);
  typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, EXEC = 2'b10, SHOW = 2'b11} state_e;
  state_e       state_q, state_d;
  logic         sync1_q, sync2_q, prev_q, armed_q, armed_d, level, press;
  logic [1:0]   fill_q;
  logic [N-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]   ctrl_q, ctrl_d;
  logic         carry_q, carry_d, valid_q, valid_d;
  // A key held low through reset must be seen released before a press can count.
  assign armed_d = armed_q | (fill_q[1] & sync2_q);
  assign press   = armed_q & prev_q & ~level;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= bus.i_key;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= level;
      armed_q <= armed_d;
    end
  end
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          deb_q, deb_d;
  always_comb begin
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = (sync2_q != deb_q && cnt_inc != LIMIT) ? cnt_inc : '0;
    deb_d   = (sync2_q != deb_q && cnt_inc == LIMIT) ? sync2_q : deb_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end
  assign level = deb_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2_q;
`endif
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = 1'b0;
    case (state_q)
      LOAD_A: if (press) begin
        a_d     = bus.i_sw;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        b_d     = bus.i_sw;
        ctrl_d  = bus.i_ctrl_sw;
        valid_d = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = bus.i_result;
        carry_d  = bus.i_carry_out;
        state_d  = SHOW;
      end
      default: state_d = press ? LOAD_A : SHOW;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.o_a        = a_q;
  assign bus.o_b        = b_q;
  assign bus.o_alu_ctrl = ctrl_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_result   = result_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_state    = state_q;
  assign bus.o_done     = state_q == SHOW;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: random and directed key/switch stimulus checked each cycle
// against a sample-window reference model; works with or without ALU_SEQ_DEBOUNCE_EN.
module tb_alu_operand_sequencer;
  localparam int D = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int WIN = D;
  localparam int LAT = 3;
  localparam int PL  = D + 2;
`else
  localparam int WIN = 1;
  localparam int LAT = 2;
  localparam int PL  = 2;
`endif
  logic clk, rst_n;
  int   checks, errors, cyc, vcount;
  alu_operand_sequencer_if #(.N(4)) bus ();
  alu_operand_sequencer #(.N(4), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
  );
  // Stand-in ALU: add, subtract (carry = no borrow), and, or.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
    int r;
    case (c)
      2'd0:    r = a + b;
      2'd1:    r = a - b + 16;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r[4:0];
  endfunction
  always_comb {bus.i_carry_out, bus.i_result} = alu_f(bus.o_a, bus.o_b, bus.o_alu_ctrl);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] m_st, m_ctrl;
  logic [3:0] m_a, m_b, m_res;
  logic       m_carry, m_valid, m_deb, m_armed;
  logic       hist[$];
  int         ev[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] dut_vec();
    return {13'd0, bus.o_state, bus.o_a, bus.o_b, bus.o_alu_ctrl, bus.o_valid,
            bus.o_result, bus.o_carry, bus.o_done};
  endfunction
  function automatic logic [31:0] model_vec();
    return {13'd0, m_st, m_a, m_b, m_ctrl, m_valid, m_res, m_carry, m_st == 2'd3};
  endfunction
  task automatic m_reset();
    m_st = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_res = 0; m_carry = 0; m_valid = 0;
    m_deb = 1; m_armed = 0;
    hist.delete();
    ev.delete();
  endtask
  // A press is a debounced fall (WIN equal samples) seen after the key was released once.
  task automatic model_edge(input logic k, input logic [3:0] sw, input logic [1:0] cs);
    logic fire, same;
    cyc++;
    fire = 0;
    while (ev.size() > 0 && ev[0] == cyc) begin
      void'(ev.pop_front());
      fire = 1;
    end
    m_valid = 0;
    case (m_st)
      2'd0: if (fire) begin m_a = sw; m_st = 2'd1; end
      2'd1: if (fire) begin m_b = sw; m_ctrl = cs; m_valid = 1; m_st = 2'd2; end
      2'd2: begin {m_carry, m_res} = alu_f(m_a, m_b, m_ctrl); m_st = 2'd3; end
      default: if (fire) m_st = 2'd0;
    endcase
    hist.push_back(k);
    if (hist.size() > WIN) void'(hist.pop_front());
    if (k) m_armed = 1;
    if (hist.size() == WIN) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != k) same = 0;
      if (same && k != m_deb) begin
        m_deb = k;
        if (!k && m_armed) ev.push_back(cyc + LAT);
      end
    end
  endtask
  task automatic step(input logic k, input logic [3:0] sw, input logic [1:0] cs);
    bus.i_key = k; bus.i_sw = sw; bus.i_ctrl_sw = cs;
    @(posedge clk);
    model_edge(k, sw, cs);
    @(negedge clk);
    if (bus.o_valid) vcount++;
    check("cycle", dut_vec(), model_vec());
  endtask
  task automatic press(input logic [3:0] sw, input logic [1:0] cs, output int lat);
    logic [1:0] st0;
    st0 = bus.o_state;
    lat = -1;
    for (int i = 0; i < PL + 4; i++) begin
      step(1'b0, sw, cs);
      if (lat < 0 && bus.o_state != st0) lat = i;
    end
    for (int i = 0; i < WIN + 6; i++) step(1'b1, sw, cs);
  endtask
  task automatic do_reset(input logic k);
    bus.i_key = k;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_async", dut_vec(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_held", dut_vec(), 32'd0);
    rst_n = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int lat, lo, hi, v0;
    logic [3:0] av;
    checks = 0; errors = 0; cyc = 0; vcount = 0;
    rst_n = 1'b1;
    bus.i_key = 1'b1; bus.i_sw = 4'h0; bus.i_ctrl_sw = 2'b00;
    @(negedge clk);
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 4'($urandom), 2'($urandom));
    check("idle_valid", 32'(vcount), 32'd0);
    check("idle_state", 32'(bus.o_state), 32'd0);
    press(4'h5, 2'b00, lat);
    check("lat_a", 32'(lat), 32'(PL));
    check("a_5", 32'(bus.o_a), 32'h5);
    v0 = vcount;
    press(4'h3, 2'b00, lat);
    check("valid_once", 32'(vcount - v0), 32'd1);
    check("b_3", 32'(bus.o_b), 32'h3);
    check("sum_8", 32'(bus.o_result), 32'h8);
    check("carry_0", 32'(bus.o_carry), 32'd0);
    check("done", 32'(bus.o_done), 32'd1);
    press(4'h0, 2'b00, lat);
    press(4'hF, 2'b00, lat);
    press(4'h1, 2'b00, lat);
    check("wrap_res", 32'(bus.o_result), 32'h0);
    check("wrap_carry", 32'(bus.o_carry), 32'd1);
    press(4'h9, 2'b11, lat);
    check("back_state", 32'(bus.o_state), 32'd0);
    check("hold_res", 32'(bus.o_result), 32'h0);
    check("hold_carry", 32'(bus.o_carry), 32'd1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < WIN - 1; i++) step(1'b0, 4'h7, 2'b01);
      for (int i = 0; i < 2 * WIN + 2; i++) step(1'b1, 4'h7, 2'b01);
    end
    check("glitch_state", 32'(bus.o_state), 32'd0);
    press(4'hA, 2'b01, lat);
    check("pulse_lat", 32'(lat), 32'(PL));
    check("pulse_state", 32'(bus.o_state), 32'd1);
    press(4'h2, 2'b01, lat);
    press(4'h0, 2'b00, lat);
    av = 4'($urandom);
    for (int i = 0; i < 50; i++) step(1'b0, i <= PL ? av : ~av, 2'b10);
    for (int i = 0; i < WIN + 6; i++) step(1'b1, ~av, 2'b10);
    check("held_state", 32'(bus.o_state), 32'd1);
    check("held_a", 32'(bus.o_a), 32'(av));
    for (int i = 0; i < PL + 4 && bus.o_state != 2'd2; i++) step(1'b0, 4'h6, 2'b00);
    check("exec_reached", 32'(bus.o_state), 32'd2);
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h6, 2'b00);
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 4'h4, 2'b00);
    check("held_rst_state", 32'(bus.o_state), 32'd0);
    for (int i = 0; i < WIN + 4; i++) step(1'b1, 4'h4, 2'b00);
    press(4'hC, 2'b00, lat);
    check("rearm_state", 32'(bus.o_state), 32'd1);
    check("rearm_a", 32'(bus.o_a), 32'hC);
    for (int r = 0; r < 300; r++) begin
      lo = $urandom_range(1, 2 * WIN + 2);
      hi = $urandom_range(1, 2 * WIN + 2);
      for (int i = 0; i < lo; i++) step(1'b0, 4'($urandom), 2'($urandom));
      for (int i = 0; i < hi; i++) step(1'b1, 4'($urandom), 2'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
